// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the MEM-stage request controller.
// The link register tracks addresses at word granularity.
package cpu_types_pkg;

    localparam int WORD_ADDR_LSB = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } memctl_state_t;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/ll_sc_link.sv
// Per-core LL/SC link register: remembers the LL word address and decides SC success.
// A set (LL completion) has priority over any clear arriving in the same cycle.
module ll_sc_link
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              set_i,
    input  logic              clr_i,
    input  logic              snoop_inv_i,
    input  logic [ADDR_W-1:0] snoop_addr_i,
    input  logic [ADDR_W-1:0] cmp_addr_i,
    output logic              sc_pass_o
);

    localparam int LINK_W = ADDR_W - WORD_ADDR_LSB;

    logic              link_valid_q;
    logic              link_valid_d;
    logic [LINK_W-1:0] link_addr_q;
    logic [LINK_W-1:0] link_addr_d;
    logic              cmp_match_s;
    logic              snoop_match_s;
    logic              unused_lsb_s;

    assign cmp_match_s   = (link_addr_q == cmp_addr_i[ADDR_W-1:WORD_ADDR_LSB]);
    assign snoop_match_s = snoop_inv_i && (link_addr_q == snoop_addr_i[ADDR_W-1:WORD_ADDR_LSB]);
    assign sc_pass_o     = link_valid_q && cmp_match_s && !snoop_match_s;
    assign unused_lsb_s  = ^{cmp_addr_i[WORD_ADDR_LSB-1:0], snoop_addr_i[WORD_ADDR_LSB-1:0]};

    // clr_i only drops the link when the store hits the linked word
    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (set_i) begin
            link_valid_d = 1'b1;
            link_addr_d  = cmp_addr_i[ADDR_W-1:WORD_ADDR_LSB];
        end else if ((clr_i && cmp_match_s) || snoop_match_s) begin
            link_valid_d = 1'b0;
        end else begin
            link_valid_d = link_valid_q;
        end
    end

    // Link register state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= {LINK_W{1'b0}};
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// MEM-stage data-access sequencer: issues dcache requests, stalls the pipe until dhit,
// resolves LL/SC through the link register, latches halt and counts stall cycles.
module mem_req_ctrl
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              datomic,
    input  logic              halt,
    input  logic              mem_adv,
    input  logic [ADDR_W-1:0] dmemaddr,
    input  logic [DATA_W-1:0] dmemstore,
    input  logic              dhit,
    input  logic [DATA_W-1:0] dmemload,
    input  logic              snoop_inv,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              dREN,
    output logic              dWEN,
    output logic [ADDR_W-1:0] daddr,
    output logic [DATA_W-1:0] dstore,
    output logic              mem_stall,
    output logic [DATA_W-1:0] load_data,
    output logic              halt_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    memctl_state_t     state_q;
    memctl_state_t     state_d;
    logic              rd_q;
    logic              rd_d;
    logic              wr_q;
    logic              wr_d;
    logic              atom_q;
    logic              atom_d;
    logic              sc_ok_q;
    logic              sc_ok_d;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] result_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    logic              dren_s;
    logic              dwen_s;
    logic              stall_s;
    logic [DATA_W-1:0] load_s;
    logic              link_set_s;
    logic              link_clr_s;
    logic              sc_pass_s;

    ll_sc_link #(
        .ADDR_W (ADDR_W)
    ) u_link (
        .CLK          (CLK),
        .RST          (RST),
        .set_i        (link_set_s),
        .clr_i        (link_clr_s),
        .snoop_inv_i  (snoop_inv),
        .snoop_addr_i (snoop_addr),
        .cmp_addr_i   (dmemaddr),
        .sc_pass_o    (sc_pass_s)
    );

    // Next-state, request and write-back selection
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        atom_d     = atom_q;
        sc_ok_d    = sc_ok_q;
        result_d   = result_q;
        dren_s     = 1'b0;
        dwen_s     = 1'b0;
        stall_s    = 1'b0;
        load_s     = {DATA_W{1'b0}};
        link_set_s = 1'b0;
        link_clr_s = 1'b0;
        case (state_q)
            IDLE: begin
                // A failing SC never requests and falls through with load_s = 0
                dren_s = memRead;
                dwen_s = memWrite && (!datomic || sc_pass_s);
                if (dren_s || dwen_s) begin
                    if (dhit) begin
                        load_s     = (dwen_s && datomic) ? {{(DATA_W-1){1'b0}}, 1'b1} : dmemload;
                        result_d   = load_s;
                        link_set_s = memRead && datomic;
                        link_clr_s = dwen_s;
                        state_d    = mem_adv ? IDLE : HOLD;
                    end else begin
                        stall_s = 1'b1;
                        rd_d    = memRead;
                        wr_d    = dwen_s;
                        atom_d  = datomic;
                        sc_ok_d = sc_pass_s;
                        state_d = BUSY;
                    end
                end else if (halt && !memRead && !memWrite) begin
                    state_d = HALTED;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                dren_s  = rd_q;
                dwen_s  = wr_q;
                stall_s = !dhit;
                if (dhit) begin
                    load_s     = (wr_q && atom_q) ? {{(DATA_W-1){1'b0}}, sc_ok_q} : dmemload;
                    result_d   = load_s;
                    link_set_s = rd_q && atom_q;
                    link_clr_s = wr_q;
                    state_d    = mem_adv ? IDLE : HOLD;
                end else begin
                    state_d = BUSY;
                end
            end
            HOLD: begin
                load_s = result_q;
                if (mem_adv) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating stall-cycle counter
    always_comb begin
        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // FSM, issue-context, result and counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            atom_q      <= 1'b0;
            sc_ok_q     <= 1'b0;
            result_q    <= {DATA_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            atom_q      <= atom_d;
            sc_ok_q     <= sc_ok_d;
            result_q    <= result_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // IDLE decodes straight from the pipe, so reset must mask the outputs directly
    assign dREN      = dren_s && !RST;
    assign dWEN      = dwen_s && !RST;
    assign mem_stall = stall_s && !RST;
    assign load_data = RST ? {DATA_W{1'b0}} : load_s;
    assign halt_out  = (state_q == HALTED) && !RST;
    assign stall_cnt = stall_cnt_q;
    assign daddr     = dmemaddr;
    assign dstore    = dmemstore;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed-vector bench for mem_req_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mem_req_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        memRead, memWrite, datomic, halt, mem_adv;
    logic [31:0] dmemaddr, dmemstore, dmemload, snoop_addr;
    logic        dhit, snoop_inv;
    logic        dREN, dWEN, mem_stall, halt_out;
    logic [31:0] daddr, dstore, load_data;
    logic [3:0]  stall_cnt;

    typedef struct {
        string       name;
        logic        ren;
        logic        wen;
        logic        stall;
        logic        chk_ld;
        logic [31:0] ld;
        logic        hout;
        logic        chk_cnt;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 CLK = ~CLK;

    mem_req_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .CNT_W  (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .datomic    (datomic),
        .halt       (halt),
        .mem_adv    (mem_adv),
        .dmemaddr   (dmemaddr),
        .dmemstore  (dmemstore),
        .dhit       (dhit),
        .dmemload   (dmemload),
        .snoop_inv  (snoop_inv),
        .snoop_addr (snoop_addr),
        .dREN       (dREN),
        .dWEN       (dWEN),
        .daddr      (daddr),
        .dstore     (dstore),
        .mem_stall  (mem_stall),
        .load_data  (load_data),
        .halt_out   (halt_out),
        .stall_cnt  (stall_cnt)
    );

    task automatic expect_c(input string nm, input logic ren, input logic wen, input logic stall,
                            input logic chk_ld, input logic [31:0] ld, input logic hout,
                            input logic chk_cnt, input logic [3:0] cnt);
        exp_t e;
        e.name = nm; e.ren = ren; e.wen = wen; e.stall = stall; e.chk_ld = chk_ld;
        e.ld = ld; e.hout = hout; e.chk_cnt = chk_cnt; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in;
        memRead = 1'b0; memWrite = 1'b0; datomic = 1'b0; halt = 1'b0; mem_adv = 1'b1;
        dhit = 1'b0; dmemload = 32'h0; snoop_inv = 1'b0; snoop_addr = 32'h0;
    endtask

    task automatic op(input logic rd, input logic wr, input logic at, input logic [31:0] addr,
                      input logic hit, input logic [31:0] ld_in);
        memRead = rd; memWrite = wr; datomic = at; dmemaddr = addr; dhit = hit; dmemload = ld_in;
    endtask

    // Scoreboard monitor
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_chk++;
            if (dREN !== mon_e.ren || dWEN !== mon_e.wen || mem_stall !== mon_e.stall ||
                halt_out !== mon_e.hout || (mon_e.chk_ld && load_data !== mon_e.ld) ||
                daddr !== dmemaddr || dstore !== dmemstore) begin
                n_fail++;
                $display("FAIL %s: got ren=%b wen=%b stall=%b ld=%h halt=%b daddr=%h dstore=%h, expected ren=%b wen=%b stall=%b ld=%h halt=%b daddr=%h dstore=%h",
                         mon_e.name, dREN, dWEN, mem_stall, load_data, halt_out, daddr, dstore,
                         mon_e.ren, mon_e.wen, mon_e.stall, mon_e.ld, mon_e.hout, dmemaddr, dmemstore);
            end
            if (mon_e.chk_cnt) begin
                n_chk++;
                if (stall_cnt !== mon_e.cnt) begin
                    n_fail++;
                    $display("FAIL %s_cnt: got stall_cnt=%0d, expected %0d", mon_e.name, stall_cnt, mon_e.cnt);
                end
            end
        end
    end

    initial begin
        RST = 1'b1;
        idle_in();
        dmemaddr = 32'h44; dmemstore = 32'h55; memRead = 1'b1;
        tick();
        expect_c("reset", 0, 0, 0, 1, 32'h0, 0, 1, 4'd0);
        tick();
        RST = 1'b0;
        idle_in();

        // LW 0x100, hit on third cycle
        op(1, 0, 0, 32'h100, 0, 32'h0); expect_c("lw_c0", 1, 0, 1, 0, 32'h0, 0, 0, 4'd0); tick();
        expect_c("lw_c1", 1, 0, 1, 0, 32'h0, 0, 0, 4'd0); tick();
        op(1, 0, 0, 32'h100, 1, 32'hDEADBEEF); expect_c("lw_hit", 1, 0, 0, 1, 32'hDEADBEEF, 0, 0, 4'd0); tick();
        idle_in(); expect_c("lw_done", 0, 0, 0, 1, 32'h0, 0, 1, 4'd2); tick();

        // LL then SC success, then a second SC that fails
        op(1, 0, 1, 32'h200, 1, 32'h1234); expect_c("ll_200", 1, 0, 0, 1, 32'h1234, 0, 0, 4'd0); tick();
        dmemstore = 32'h5;
        op(0, 1, 1, 32'h200, 0, 32'h0); expect_c("sc_miss", 0, 1, 1, 0, 32'h0, 0, 0, 4'd0); tick();
        op(0, 1, 1, 32'h200, 1, 32'h0); expect_c("sc_hit", 0, 1, 0, 1, 32'h1, 0, 0, 4'd0); tick();
        op(0, 1, 1, 32'h200, 0, 32'h0); expect_c("sc_again", 0, 0, 0, 1, 32'h0, 0, 1, 4'd3); tick();

        // Snoop coinciding with SC kills it and the link
        op(1, 0, 1, 32'h200, 1, 32'h11); expect_c("ll_200b", 1, 0, 0, 1, 32'h11, 0, 0, 4'd0); tick();
        op(0, 1, 1, 32'h200, 0, 32'h0); snoop_inv = 1'b1; snoop_addr = 32'h200;
        expect_c("sc_snooped", 0, 0, 0, 1, 32'h0, 0, 0, 4'd0); tick();
        snoop_inv = 1'b0; expect_c("sc_after_snoop", 0, 0, 0, 1, 32'h0, 0, 0, 4'd0); tick();

        // LL coinciding with a snoop to the same word keeps the link
        op(1, 0, 1, 32'h300, 1, 32'h22); snoop_inv = 1'b1; snoop_addr = 32'h300;
        expect_c("ll_vs_snoop", 1, 0, 0, 1, 32'h22, 0, 0, 4'd0); tick();
        snoop_inv = 1'b0;
        op(0, 1, 1, 32'h300, 1, 32'h0); expect_c("sc_300", 0, 1, 0, 1, 32'h1, 0, 0, 4'd0); tick();

        // Failed SC to another word leaves the link intact
        op(1, 0, 1, 32'h400, 1, 32'h33); expect_c("ll_400", 1, 0, 0, 1, 32'h33, 0, 0, 4'd0); tick();
        op(0, 1, 1, 32'h404, 0, 32'h0); expect_c("sc_404", 0, 0, 0, 1, 32'h0, 0, 0, 4'd0); tick();
        op(0, 1, 1, 32'h400, 1, 32'h0); expect_c("sc_400", 0, 1, 0, 1, 32'h1, 0, 0, 4'd0); tick();

        // Plain SW to the linked word clears the link
        op(1, 0, 1, 32'h500, 1, 32'h44); expect_c("ll_500", 1, 0, 0, 1, 32'h44, 0, 0, 4'd0); tick();
        op(0, 1, 0, 32'h500, 1, 32'h0); expect_c("sw_500", 0, 1, 0, 1, 32'h0, 0, 0, 4'd0); tick();
        op(0, 1, 1, 32'h500, 0, 32'h0); expect_c("sc_500", 0, 0, 0, 1, 32'h0, 0, 0, 4'd0); tick();

        // Snoop to an unrelated word does not break the link
        op(1, 0, 1, 32'h600, 1, 32'h66); expect_c("ll_600", 1, 0, 0, 1, 32'h66, 0, 0, 4'd0); tick();
        op(0, 1, 1, 32'h600, 1, 32'h0); snoop_inv = 1'b1; snoop_addr = 32'h700;
        expect_c("sc_600_other_snoop", 0, 1, 0, 1, 32'h1, 0, 0, 4'd0); tick();
        snoop_inv = 1'b0;

        // LW completes without mem_adv: HOLD replays the captured result
        op(1, 0, 0, 32'h700, 1, 32'h77); mem_adv = 1'b0; expect_c("lw_hold_hit", 1, 0, 0, 1, 32'h77, 0, 0, 4'd0); tick();
        op(1, 0, 0, 32'h700, 0, 32'h99); expect_c("hold_c1", 0, 0, 0, 1, 32'h77, 0, 0, 4'd0); tick();
        mem_adv = 1'b1; expect_c("hold_adv", 0, 0, 0, 1, 32'h77, 0, 0, 4'd0); tick();
        op(1, 0, 0, 32'h900, 1, 32'h5A); expect_c("lw_after_hold", 1, 0, 0, 1, 32'h5A, 0, 0, 4'd0); tick();

        // SW completes without mem_adv: no reissue during HOLD
        dmemstore = 32'hAA;
        op(0, 1, 0, 32'h800, 1, 32'h0); mem_adv = 1'b0; expect_c("sw_hold_hit", 0, 1, 0, 1, 32'h0, 0, 0, 4'd0); tick();
        op(0, 1, 0, 32'h800, 0, 32'h0); expect_c("sw_hold_c1", 0, 0, 0, 1, 32'h0, 0, 0, 4'd0); tick();
        mem_adv = 1'b1; expect_c("sw_hold_adv", 0, 0, 0, 1, 32'h0, 0, 0, 4'd0); tick();
        idle_in(); expect_c("sw_idle", 0, 0, 0, 1, 32'h0, 0, 1, 4'd3); tick();

        // Long miss saturates the 4-bit counter
        op(1, 0, 0, 32'hA00, 0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            expect_c("long_miss", 1, 0, 1, 0, 32'h0, 0, 0, 4'd0);
            tick();
        end
        op(1, 0, 0, 32'hA00, 1, 32'hCAFE); expect_c("long_hit", 1, 0, 0, 1, 32'hCAFE, 0, 1, 4'd15); tick();
        idle_in(); expect_c("sat_hold", 0, 0, 0, 1, 32'h0, 0, 1, 4'd15); tick();

        // Reset while BUSY drops the request immediately
        op(1, 0, 0, 32'hB00, 0, 32'h0); expect_c("busy_pre_rst", 1, 0, 1, 0, 32'h0, 0, 0, 4'd0); tick();
        expect_c("busy_rst", 0, 0, 0, 1, 32'h0, 0, 1, 4'd0);
        #2 RST = 1'b1;
        tick();
        idle_in(); RST = 1'b0;
        expect_c("post_rst", 0, 0, 0, 1, 32'h0, 0, 1, 4'd0); tick();

        // Halt is sticky and blocks later requests
        halt = 1'b1; expect_c("halt_in", 0, 0, 0, 1, 32'h0, 0, 0, 4'd0); tick();
        halt = 1'b0; op(1, 0, 0, 32'hC00, 0, 32'h0); expect_c("halted_rd", 0, 0, 0, 1, 32'h0, 1, 0, 4'd0); tick();
        op(1, 0, 0, 32'hC00, 1, 32'h1); expect_c("halted_rd_hit", 0, 0, 0, 1, 32'h0, 1, 1, 4'd0); tick();

        idle_in();
        tick();
        tick();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
